// File: rtl/step_counter_if.sv
// Control/status bundle for step_counter: advance/load controls in, count and flags out.
interface step_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic              sat_mode;
  logic              clr_sticky;
  logic [WIDTH-1:0]  count;
  logic              ovf_pulse;
  logic              ovf_sticky;
  logic              at_max;
  logic              at_min;

  modport master (
    output en, load, load_val, dir, step, sat_mode, clr_sticky,
    input  count, ovf_pulse, ovf_sticky, at_max, at_min
  );

  modport slave (
    input  en, load, load_val, dir, step, sat_mode, clr_sticky,
    output count, ovf_pulse, ovf_sticky, at_max, at_min
  );
endinterface

// File: rtl/step_counter.sv
// Registered up/down counter with programmable step, wrap/saturate modes and
// carry/borrow reporting as a one-cycle pulse plus a sticky flag.
module step_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  step_counter_if.slave  bus
);
  logic [WIDTH-1:0] r_count;
  logic             r_ovf_pulse;
  logic             r_ovf_sticky;

  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_adv;
  logic             w_event;
  logic [WIDTH-1:0] w_next;

  // One extra bit holds the carry (up) or the borrow sign (down).
  assign w_step_ext = {{(WIDTH+1-STEP_W){1'b0}}, bus.step};
  assign w_sum      = {1'b0, r_count} + w_step_ext;
  assign w_diff     = {1'b0, r_count} - w_step_ext;
  assign w_adv      = bus.en & ~bus.load;
  assign w_event    = w_adv & (bus.dir ? w_diff[WIDTH] : w_sum[WIDTH]);

  always_comb begin
    w_next = r_count;
    if (bus.load) begin
      w_next = bus.load_val;
    end else if (bus.en) begin
      if (w_event && bus.sat_mode)
        w_next = bus.dir ? '0 : '1;
      else
        w_next = bus.dir ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_ovf_pulse  <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_count      <= w_next;
      r_ovf_pulse  <= w_event;
      // A new event wins over a clear in the same cycle.
      r_ovf_sticky <= w_event | (r_ovf_sticky & ~bus.clr_sticky);
    end
  end

  assign bus.count      = r_count;
  assign bus.ovf_pulse  = r_ovf_pulse;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.at_max     = (r_count == '1);
  assign bus.at_min     = (r_count == '0);
endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one cycle after each edge.
module tb_step_counter;
  logic clk;
  logic reset;

  step_counter_if #(.WIDTH(8), .STEP_W(4)) bus ();

  step_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] cnt;
    logic       p;
    logic       s;
    logic       mx;
    logic       mn;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: every post-edge sample is a DUT output; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk(e.nm, "count",  bus.count,            e.cnt);
        chk(e.nm, "pulse",  {7'd0, bus.ovf_pulse},  {7'd0, e.p});
        chk(e.nm, "sticky", {7'd0, bus.ovf_sticky}, {7'd0, e.s});
        chk(e.nm, "at_max", {7'd0, bus.at_max},     {7'd0, e.mx});
        chk(e.nm, "at_min", {7'd0, bus.at_min},     {7'd0, e.mn});
      end
    end
  end

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic cyc(input string nm, input logic r, input logic e, input logic l,
                     input logic [7:0] lv, input logic d, input logic [3:0] st,
                     input logic sm, input logic cl,
                     input logic [7:0] ec, input logic ep, input logic es,
                     input logic emx, input logic emn);
    exp_t x;
    @(negedge clk);
    reset          = r;
    bus.en         = e;
    bus.load       = l;
    bus.load_val   = lv;
    bus.dir        = d;
    bus.step       = st;
    bus.sat_mode   = sm;
    bus.clr_sticky = cl;
    x.nm = nm; x.cnt = ec; x.p = ep; x.s = es; x.mx = emx; x.mn = emn;
    sbq.push_back(x);
  endtask

  initial begin
    reset = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.load_val = 8'h00; bus.dir = 1'b0;
    bus.step = 4'd0; bus.sat_mode = 1'b0; bus.clr_sticky = 1'b0;

    //   name        rst en ld lv     dir st  sm cl   cnt   p  s  mx mn
    cyc("reset",      1, 0, 0, 8'h00, 0, 0,  0, 0,   8'd0,  0, 0, 0, 1);
    cyc("up3_a",      0, 1, 0, 8'h00, 0, 3,  0, 0,   8'd3,  0, 0, 0, 0);
    cyc("up3_b",      0, 1, 0, 8'h00, 0, 3,  0, 0,   8'd6,  0, 0, 0, 0);
    cyc("up3_c",      0, 1, 0, 8'h00, 0, 3,  0, 0,   8'd9,  0, 0, 0, 0);
    cyc("up3_d",      0, 1, 0, 8'h00, 0, 3,  0, 0,   8'd12, 0, 0, 0, 0);
    cyc("ld254",      0, 0, 1, 8'd254,0, 0,  0, 0,   8'd254,0, 0, 0, 0);
    cyc("wrap_up",    0, 1, 0, 8'h00, 0, 3,  0, 0,   8'd1,  1, 1, 0, 0);
    cyc("idle_stk",   0, 0, 0, 8'h00, 0, 0,  0, 0,   8'd1,  0, 1, 0, 0);
    cyc("clr_stk",    0, 0, 0, 8'h00, 0, 0,  0, 1,   8'd1,  0, 0, 0, 0);
    cyc("ld5",        0, 0, 1, 8'd5,  0, 0,  0, 0,   8'd5,  0, 0, 0, 0);
    cyc("satdn_a",    0, 1, 0, 8'h00, 1, 7,  1, 0,   8'd0,  1, 1, 0, 1);
    cyc("satdn_b",    0, 1, 0, 8'h00, 1, 7,  1, 0,   8'd0,  1, 1, 0, 1);
    cyc("clr2",       0, 0, 0, 8'h00, 0, 0,  0, 1,   8'd0,  0, 0, 0, 1);
    cyc("ld_over_en", 0, 1, 1, 8'h80, 0, 15, 0, 0,   8'h80, 0, 0, 0, 0);
    cyc("rst_over_ld",1, 0, 1, 8'h55, 0, 0,  0, 0,   8'd0,  0, 0, 0, 1);
    cyc("ld255",      0, 0, 1, 8'd255,0, 0,  0, 0,   8'd255,0, 0, 1, 0);
    cyc("race",       0, 1, 0, 8'h00, 0, 1,  0, 1,   8'd0,  1, 1, 0, 1);
    cyc("ld255_clr",  0, 0, 1, 8'd255,0, 0,  0, 1,   8'd255,0, 0, 1, 0);
    cyc("step0",      0, 1, 0, 8'h00, 0, 0,  0, 0,   8'd255,0, 0, 1, 0);
    cyc("hold_a",     0, 0, 0, 8'h00, 0, 0,  0, 0,   8'd255,0, 0, 1, 0);
    cyc("hold_b",     0, 0, 0, 8'h00, 0, 0,  0, 0,   8'd255,0, 0, 1, 0);
    cyc("hold_c",     0, 0, 0, 8'h00, 0, 0,  0, 0,   8'd255,0, 0, 1, 0);
    cyc("ld2",        0, 0, 1, 8'd2,  0, 0,  0, 0,   8'd2,  0, 0, 0, 0);
    cyc("wrap_dn",    0, 1, 0, 8'h00, 1, 5,  0, 0,   8'd253,1, 1, 0, 0);
    cyc("dn_nobor",   0, 1, 0, 8'h00, 1, 13, 0, 0,   8'd240,0, 1, 0, 0);
    cyc("ld250",      0, 0, 1, 8'd250,0, 0,  0, 1,   8'd250,0, 0, 0, 0);
    cyc("satup_a",    0, 1, 0, 8'h00, 0, 15, 1, 0,   8'd255,1, 1, 1, 0);
    cyc("satup_b",    0, 1, 0, 8'h00, 0, 1,  1, 0,   8'd255,1, 1, 1, 0);
    cyc("rst_evt",    1, 1, 0, 8'h00, 0, 15, 0, 0,   8'd0,  0, 0, 0, 1);

    @(negedge clk);
    bus.en = 1'b0; bus.load = 1'b0; reset = 1'b0; bus.clr_sticky = 1'b0;
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain actual=%0d required=0 pending", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/step_counter.md
# step_counter

Parametrised, registered successor to the 8-bit combinational increment-by-one unit in the ALU datapath. It keeps a WIDTH-bit count that advances each enabled cycle by a programmable step, up or down. Each update either wraps modulo 2^WIDTH or saturates at the range limit. Carry/borrow is reported as a one-cycle pulse and as a sticky flag. The block serves as the ALU's loop and address counter, replacing chains of plus-one instances.

## Interface
- WIDTH, 8, count width in bits (≥2)
- STEP_W, 4, step input width in bits (1 ≤ STEP_W ≤ WIDTH)

- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- en  input  1  advance count by step this cycle
- load  input  1  load load_val this cycle
- load_val  input  WIDTH  value written on load
- dir  input  1  0 = count up, 1 = count down
- step  input  STEP_W  unsigned step magnitude, zero-extended to WIDTH+1
- sat_mode  input  1  0 = wrap modulo 2^WIDTH, 1 = saturate
- clr_sticky  input  1  clear ovf_sticky
- count  output  WIDTH  registered count
- ovf_pulse  output  1  registered; high for exactly the cycle after a carry/borrow event
- ovf_sticky  output  1  registered; set on any carry/borrow event, held until cleared
- at_max  output  1  combinational from count: count == 2^WIDTH−1
- at_min  output  1  combinational from count: count == 0

## Operation
- Priority per rising edge: reset > load > en > hold.
- Reset values:
  - count = 0
  - ovf_pulse = 0
  - ovf_sticky = 0
  - at_min = 1 after reset; at_max = 0.
- Load:
  - count ← load_val.
  - ovf_pulse ← 0; no event is generated.
  - Sticky only changes via clr_sticky.
  - en is ignored in the same cycle.
- Advance (en=1, load=0): compute in WIDTH+1 bits.
  - Up: sum = {0,count} + {0,step}. Event when sum[WIDTH] = 1.
  - Down: diff = {0,count} − {0,step}. Event (borrow) when step > count, i.e. diff[WIDTH] = 1.
  - No event: count ← sum or diff [WIDTH−1:0].
  - Event, sat_mode = 0: count ← result[WIDTH−1:0] (modulo wrap).
  - Event, sat_mode = 1: count ← 2^WIDTH−1 for up, 0 for down.
  - step = 0: count unchanged, no event.
  - Saturating at a limit and stepping further toward it counts as an event every cycle. Example: up at 255, step 1 → pulse each cycle.
- Hold (en = 0, load = 0): count unchanged, ovf_pulse ← 0.
- Pulse and sticky:
  - ovf_pulse ← event, for every non-reset cycle.
  - ovf_sticky ← event | (ovf_sticky & ~clr_sticky). A simultaneous event and clear leaves the flag set.
- dir, step and sat_mode are sampled only in the cycle en is applied; changing them between cycles is legal.

## Timing
- Latency: 1 cycle.
  - count, ovf_pulse and ovf_sticky reflect inputs sampled at edge N immediately after edge N.
  - at_max and at_min follow count in the same cycle (no extra register).
- Throughput: one update per cycle, with no stall or bubble.
- Reset mid-operation: the next edge forces reset values regardless of en/load/clr_sticky. A pending event in that cycle is discarded.
- All outputs are glitch-free registers except at_max and at_min, which are decoded from count.

## Test plan
- Reset then up-count (WIDTH=8, STEP_W=4): reset=1 one cycle, then en=1, dir=0, step=3 for 4 cycles.
  - count = 0, 3, 6, 9, 12.
  - ovf_pulse stays 0; at_min = 1 only before the first step.
- Wrap up: load 254, then en, step=3, sat_mode=0.
  - count = 1; ovf_pulse = 1 for one cycle; ovf_sticky = 1 and stays set.
  - clr_sticky on the next idle cycle → ovf_sticky = 0.
- Saturate down: load 5, dir=1, step=7, sat_mode=1, en for 2 cycles.
  - count = 0 both cycles; ovf_pulse = 1 both cycles; at_min = 1.
- Priority: a cycle with load=1, load_val=0x80, en=1, step=15 → count = 0x80, ovf_pulse = 0.
  - A cycle with reset=1 and load=1 → count = 0.
- Sticky race: count=255, en, dir=0, step=1, sat_mode=0, with clr_sticky=1 in the same cycle.
  - count = 0; ovf_pulse = 1; ovf_sticky = 1.
- Step zero and hold: en=1, step=0 at count=255 → count stays 255, at_max = 1, no pulse.
  - en=0 for 3 cycles → count stays 255, ovf_pulse = 0.
